// File: rtl/time_fmt_conv_pipe.sv
// Two-stage, valid-qualified 24h -> 12h/24h display-time converter with range check,
// last-good hold on bad samples, and a mode-change flash indicator.
module time_fmt_conv_pipe #(
  parameter int unsigned HOUR_W       = 5,
  parameter int unsigned MIN_W        = 6,
  parameter int unsigned SEC_W        = 6,
  parameter int unsigned FLASH_CYCLES = 50000000,
  parameter int unsigned TIME_W       = HOUR_W + MIN_W + SEC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mod12_24,
  input  logic              in_valid,
  input  logic [TIME_W-1:0] in_disp_time,
  output logic              out_valid,
  output logic [TIME_W-1:0] out_disp_time,
  output logic              led0,
  output logic              err,
  output logic              mode_flash
);

  localparam int unsigned CNT_W = (FLASH_CYCLES == 0) ? 1 : $clog2(FLASH_CYCLES + 1);

  logic [HOUR_W-1:0] w_hh;
  logic [MIN_W-1:0]  w_mm;
  logic [SEC_W-1:0]  w_ss;
  logic              w_bad;

  assign w_hh  = in_disp_time[TIME_W-1 -: HOUR_W];
  assign w_mm  = in_disp_time[SEC_W +: MIN_W];
  assign w_ss  = in_disp_time[SEC_W-1:0];
  assign w_bad = (w_hh > HOUR_W'(23)) | (w_mm > MIN_W'(59)) | (w_ss > SEC_W'(59));

  logic              r_s1_valid;
  logic [TIME_W-1:0] r_s1_time;
  logic              r_s1_mode;
  logic              r_s1_bad;

  // Mode is captured alongside the sample so later mode changes cannot affect it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_time  <= '0;
      r_s1_mode  <= 1'b0;
      r_s1_bad   <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_time <= in_disp_time;
        r_s1_mode <= mod12_24;
        r_s1_bad  <= w_bad;
      end
    end
  end

  logic [HOUR_W-1:0] w_s1_hh;
  logic [HOUR_W-1:0] w_conv_hh;
  logic              w_pm;
  logic [TIME_W-1:0] w_conv_time;

  assign w_s1_hh = r_s1_time[TIME_W-1 -: HOUR_W];

  always_comb begin
    w_conv_hh = w_s1_hh;
    w_pm      = 1'b0;
    if (r_s1_mode) begin
      if (w_s1_hh == '0) begin
        w_conv_hh = HOUR_W'(12);
      end else if (w_s1_hh == HOUR_W'(12)) begin
        w_pm = 1'b1;
      end else if (w_s1_hh > HOUR_W'(12)) begin
        w_conv_hh = w_s1_hh - HOUR_W'(12);
        w_pm      = 1'b1;
      end
    end
  end

  assign w_conv_time = {w_conv_hh, r_s1_time[MIN_W+SEC_W-1:0]};

  // Bad samples still pulse out_valid but leave the displayed time untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid     <= 1'b0;
      out_disp_time <= '0;
      led0          <= 1'b0;
      err           <= 1'b0;
    end else begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_bad) begin
          err <= 1'b1;
        end else begin
          err           <= 1'b0;
          out_disp_time <= w_conv_time;
          led0          <= w_pm;
        end
      end
    end
  end

  logic             r_mode_prev;
  logic [CNT_W-1:0] r_flash_cnt;
  logic [CNT_W-1:0] w_flash_cnt_next;

  always_comb begin
    w_flash_cnt_next = r_flash_cnt;
    if (mod12_24 != r_mode_prev) begin
      w_flash_cnt_next = CNT_W'(FLASH_CYCLES);
    end else if (r_flash_cnt != '0) begin
      w_flash_cnt_next = r_flash_cnt - CNT_W'(1);
    end
  end

  // mode_flash tracks the counter's next value so it is high exactly while the count is non-zero.
  always_ff @(posedge clk) begin
    r_mode_prev <= mod12_24;
    if (!reset) begin
      r_flash_cnt <= '0;
      mode_flash  <= 1'b0;
    end else begin
      r_flash_cnt <= w_flash_cnt_next;
      mode_flash  <= (w_flash_cnt_next != '0);
    end
  end

endmodule

// File: tb/tb_time_fmt_conv_pipe.sv
// Scoreboard bench for time_fmt_conv_pipe: directed samples push hand-computed
// expectations; a negedge monitor pops and checks each out_valid pulse.
module tb_time_fmt_conv_pipe;

  localparam int unsigned TW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          mod12_24;
  logic          in_valid;
  logic [TW-1:0] in_disp_time;
  logic          out_valid;
  logic [TW-1:0] out_disp_time;
  logic          led0;
  logic          err;
  logic          mode_flash;

  time_fmt_conv_pipe #(
    .HOUR_W(5),
    .MIN_W(6),
    .SEC_W(6),
    .FLASH_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mod12_24(mod12_24),
    .in_valid(in_valid),
    .in_disp_time(in_disp_time),
    .out_valid(out_valid),
    .out_disp_time(out_disp_time),
    .led0(led0),
    .err(err),
    .mode_flash(mode_flash)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] t;
    logic          led;
    logic          e;
    int unsigned   cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_exp;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc++;

  function automatic logic [TW-1:0] tm(input int unsigned h, input int unsigned m, input int unsigned s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  always @(negedge clk) begin
    if (out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: got out=%h at cycle %0d, required no output", out_disp_time, cyc);
      end else begin
        m_exp = q.pop_front();
        if (out_disp_time !== m_exp.t || led0 !== m_exp.led || err !== m_exp.e || cyc != m_exp.cyc + 2) begin
          n_bad++;
          $display("FAIL sample_out: got time=%h led0=%b err=%b cyc=%0d, required time=%h led0=%b err=%b cyc=%0d",
                   out_disp_time, led0, err, cyc, m_exp.t, m_exp.led, m_exp.e, m_exp.cyc + 2);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic send(input int unsigned h, input int unsigned m, input int unsigned s, input logic mode,
                      input int unsigned eh, input int unsigned em, input int unsigned es,
                      input logic eled, input logic eerr);
    exp_t x;
    mod12_24     = mode;
    in_valid     = 1'b1;
    in_disp_time = tm(h, m, s);
    x.t   = tm(eh, em, es);
    x.led = eled;
    x.e   = eerr;
    x.cyc = cyc;
    q.push_back(x);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_time"}, 32'(out_disp_time), 32'd0);
    chk({tag, "_led0"}, 32'(led0), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_flash"}, 32'(mode_flash), 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    mod12_24     = 1'b1;
    in_valid     = 1'b0;
    in_disp_time = '0;
    idle(3);
    chk_reset_state("reset");
    reset = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      step();
      chk("no_flash_after_release", 32'(mode_flash), 32'd0);
    end

    // 12h hour boundaries, back-to-back
    send(0, 5, 0, 1'b1, 12, 5, 0, 1'b0, 1'b0);
    send(11, 59, 59, 1'b1, 11, 59, 59, 1'b0, 1'b0);
    send(12, 0, 0, 1'b1, 12, 0, 0, 1'b1, 1'b0);
    send(23, 59, 59, 1'b1, 11, 59, 59, 1'b1, 1'b0);
    idle(3);

    // range error and recovery
    send(10, 10, 10, 1'b1, 10, 10, 10, 1'b0, 1'b0);
    send(24, 0, 0, 1'b1, 10, 10, 10, 1'b0, 1'b1);
    send(9, 60, 0, 1'b1, 10, 10, 10, 1'b0, 1'b1);
    send(10, 0, 61, 1'b1, 10, 10, 10, 1'b0, 1'b1);
    send(1, 2, 3, 1'b1, 1, 2, 3, 1'b0, 1'b0);
    idle(3);

    // per-sample mode capture
    send(15, 0, 0, 1'b1, 3, 0, 0, 1'b1, 1'b0);
    send(15, 0, 0, 1'b0, 15, 0, 0, 1'b0, 1'b0);
    idle(8);

    // 24h pass-through
    send(13, 45, 30, 1'b0, 13, 45, 30, 1'b0, 1'b0);
    idle(8);

    // mode flash, then restart at count 2
    chk("flash_idle", 32'(mode_flash), 32'd0);
    mod12_24 = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      step();
      chk($sformatf("flash_single_%0d", k), 32'(mode_flash), (k < 4) ? 32'd1 : 32'd0);
    end
    mod12_24 = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk($sformatf("flash_pre_restart_%0d", k), 32'(mode_flash), 32'd1);
    end
    mod12_24 = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      step();
      chk($sformatf("flash_restart_%0d", k), 32'(mode_flash), (k < 4) ? 32'd1 : 32'd0);
    end

    // reset mid-pipeline: accepted sample must never appear
    in_valid     = 1'b1;
    in_disp_time = tm(5, 6, 7);
    step();
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    chk_reset_state("mid_reset");
    reset = 1'b1;
    idle(3);
    send(7, 8, 9, 1'b1, 7, 8, 9, 1'b0, 1'b0);
    send(20, 0, 0, 1'b1, 8, 0, 0, 1'b1, 1'b0);

    for (int unsigned k = 0; k < 20 && q.size() != 0; k++) step();
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outputs pending, required 0", q.size());
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_fmt_conv_pipe.md
Name: time_fmt_conv_pipe

Overview:
- Registered, parametrised 24h→12h/24h display-time converter for the alarm clock display path.
- Sits between the time/alarm selection mux and the 7-segment driver.
- Adds over the current pass-through stage: a valid-qualified 2-stage pipeline, real 12h AM/PM conversion, range checking with last-good hold, and a mode-change flash indicator.

Parameters:
- HOUR_W, 5: hour field width; must be ≥5.
- MIN_W, 6: minute field width; must be ≥6.
- SEC_W, 6: second field width; must be ≥6.
- FLASH_CYCLES, 50000000: cycles mode_flash stays high after a mode change; 0 disables the flash.
- TIME_W, HOUR_W+MIN_W+SEC_W: derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- mod12_24  in  1  1 = 12h AM/PM, 0 = 24h.
- in_valid  in  1  in_disp_time holds a new sample this cycle.
- in_disp_time  in  TIME_W  {hours, minutes, seconds}, unsigned binary, 24h format; hours in MSBs.
- out_valid  out  1  out_disp_time/led0/err updated this cycle.
- out_disp_time  out  TIME_W  time in selected format, same field layout.
- led0  out  1  PM indicator; 1 only in 12h mode for hours 12–23.
- err  out  1  last sample was out of range.
- mode_flash  out  1  high while mode-change indication is active.

Behaviour:
- Reset (reset==0 at a clk edge): out_valid=0, out_disp_time=0, led0=0, err=0, mode_flash=0, flash counter=0, all pipeline valids=0. mode_prev loads mod12_24 so release from reset causes no flash. Reset mid-operation discards in-flight samples; no out_valid for them.
- Stage 1 (edge where in_valid=1):
  - register sample and mod12_24 (mode is sampled per sample; later mode changes do not affect in-flight samples);
  - compute range flag bad = (hh>23)|(mm>59)|(ss>59).
- Stage 2: registers outputs; out_valid asserts exactly 2 cycles after in_valid, one cycle per accepted sample. Back-to-back samples are accepted every cycle, with no stall and no backpressure.
- 24h mode conversion: out_disp_time = input unchanged; led0=0.
- 12h mode conversion (minutes and seconds pass unchanged):
  - hh=0 → 12, led0=0.
  - hh 1–11 → hh, led0=0.
  - hh=12 → 12, led0=1.
  - hh 13–23 → hh−12, led0=1.
- Arithmetic: subtraction is HOUR_W wide; no carry into the minute field.
- Bad sample:
  - out_valid still pulses; err=1;
  - out_disp_time and led0 hold the previous registered values (0 after reset).
  - err stays 1 until the next good sample reaches stage 2, which clears it in that same cycle.
- Outputs hold their values between out_valid pulses.
- Mode flash:
  - mode_prev registers mod12_24 every cycle.
  - When mod12_24 != mode_prev, the counter loads FLASH_CYCLES.
  - The counter decrements to 0 otherwise; mode_flash = (counter != 0), registered.
  - A change during an active flash reloads the counter (restart, not extend).
  - FLASH_CYCLES=0 → mode_flash constantly 0.
  - Flash is independent of in_valid.
- Counter width = $clog2(FLASH_CYCLES+1), min 1.
- All outputs registered; no combinational path from input to output.

Test Plan:
- 24h pass-through: mod12_24=0, in_valid pulse with 13:45:30 → out_valid 2 cycles later, out=13:45:30, led0=0, err=0.
- 12h hour boundaries: mod12_24=1, back-to-back samples 00:05:00, 11:59:59, 12:00:00, 23:59:59 → consecutive out_valid cycles with:
  - 12:05:00 led0=0;
  - 11:59:59 led0=0;
  - 12:00:00 led0=1;
  - 11:59:59 led0=1.
- Range error and recovery:
  - after good 10:10:10, send 24:00:00 → err=1, out holds 10:10:10;
  - then 09:60:00 → err=1, still 10:10:10;
  - then 01:02:03 → err=0, out=01:02:03.
- Per-sample mode capture: send 15:00:00 with mod12_24=1, flip to 0 the next cycle and send 15:00:00 again → outputs 03:00:00 led0=1, then 15:00:00 led0=0.
- Mode flash (FLASH_CYCLES=4):
  - toggle mod12_24 → mode_flash high for exactly 4 cycles starting 1 cycle after the change;
  - toggle again at count 2 → restarts 4 cycles;
  - holding mod12_24=1 through reset release → no flash.
- Reset mid-pipeline: in_valid at cycle 0, reset low at cycle 1 → no out_valid; all outputs 0 the cycle after reset; normal operation resumes after release.
